spi_controller_cfg: RTL and testbench

//   Parametrised successor to the fixed 8-bit, mode-0-only SPI controller. Full-duplex SPI controller

---
 rtl/spi_pkg.sv | 20 ++
 rtl/spi_clk_gen.sv | 40 ++++
 rtl/spi_controller_cfg.sv | 164 ++++++++++++++++
 tb/tb_spi_controller_cfg.sv | 256 +++++++++++++++++++++++++
 4 files changed

// File: rtl/spi_pkg.sv
// Shared types and helpers for the configurable SPI controller.
package spi_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SETUP = 2'd1,
    ST_SHIFT = 2'd2,
    ST_HOLD  = 2'd3
  } state_e;

  // Bit positions inside the 2-bit {CPOL,CPHA} mode field
  localparam int unsigned MODE_CPOL = 1;
  localparam int unsigned MODE_CPHA = 0;

  // Bits needed to hold the values 0..n-1 (never less than one bit)
  function automatic int unsigned bits_for_count(input int unsigned n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/spi_clk_gen.sv
// Divider that emits a one-cycle tick every CLK_DIV clocks while enabled.
module spi_clk_gen
  import spi_pkg::*;
#(
  parameter int unsigned CLK_DIV = 2
) (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic en_i,
  output logic tick_o
);

  localparam int unsigned    CW   = bits_for_count(CLK_DIV);
  localparam logic [CW-1:0] LAST = CW'(CLK_DIV - 1);

  logic [CW-1:0] cnt_q, cnt_d;

  assign tick_o = en_i && (cnt_q == LAST);

  // Held at zero while disabled so every enable starts a full period
  always_comb begin
    cnt_d = cnt_q;
    if (!en_i) begin
      cnt_d = '0;
    end else if (tick_o) begin
      cnt_d = '0;
    end else begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/spi_controller_cfg.sv
// Full-duplex SPI controller: configurable width, SCLK divider, per-transfer
// CPOL/CPHA and bit order. SCLK, CS and COPI are plain registers on i_clk.
module spi_controller_cfg
  import spi_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = 8,
  parameter int unsigned CLK_DIV    = 2,
  parameter bit          MSB_FIRST  = 1'b1
) (
  input  logic                  i_clk,
  input  logic                  i_reset_n,
  input  logic [DATA_WIDTH-1:0] i_tx_data,
  input  logic                  i_tx_dv,
  input  logic [1:0]            i_mode,
  output logic                  o_tx_ready,
  output logic                  o_rx_dv,
  output logic [DATA_WIDTH-1:0] o_rx_data,
  output logic                  o_spi_clk,
  output logic                  o_spi_copi,
  input  logic                  i_spi_cipo,
  output logic                  o_spi_cs_n
);

  localparam int unsigned    EW        = bits_for_count(2 * DATA_WIDTH + 1);
  localparam logic [EW-1:0] LAST_EDGE = EW'(2 * DATA_WIDTH - 1);

  function automatic logic head_bit(input logic [DATA_WIDTH-1:0] v);
    return MSB_FIRST ? v[DATA_WIDTH-1] : v[0];
  endfunction

  function automatic logic [DATA_WIDTH-1:0] advance(input logic [DATA_WIDTH-1:0] v);
    return MSB_FIRST ? (v << 1) : (v >> 1);
  endfunction

  state_e                state_q, state_d;
  logic [DATA_WIDTH-1:0] tx_sh_q, tx_sh_d, rx_sh_q, rx_sh_d, rx_data_q, rx_data_d;
  logic [EW-1:0]         edge_q, edge_d;
  logic [1:0]            mode_q, mode_d;
  logic                  ready_q, ready_d, rx_dv_q, rx_dv_d;
  logic                  sclk_q, sclk_d, copi_q, copi_d, cs_n_q, cs_n_d;
  logic                  tick, clk_en, accept, edge_now, leading, sample;

  assign accept   = i_tx_dv && ready_q;
  assign clk_en   = (state_q != ST_IDLE);
  // The tick that ends SETUP is SCLK edge 1; SHIFT carries edges 2..2W
  assign edge_now = tick && ((state_q == ST_SETUP) || (state_q == ST_SHIFT));
  assign leading  = ~edge_q[0];
  assign sample   = leading ^ mode_q[MODE_CPHA];

  spi_clk_gen #(.CLK_DIV(CLK_DIV)) u_clk_gen (
    .clk_i  (i_clk),
    .rst_ni (i_reset_n),
    .en_i   (clk_en),
    .tick_o (tick)
  );

  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE:  if (accept) state_d = ST_SETUP;
      ST_SETUP: if (tick) state_d = ST_SHIFT;
      ST_SHIFT: if (tick && (edge_q == LAST_EDGE)) state_d = ST_HOLD;
      ST_HOLD:  if (tick) state_d = ST_IDLE;
      default:  state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    tx_sh_d   = tx_sh_q;
    rx_sh_d   = rx_sh_q;
    rx_data_d = rx_data_q;
    edge_d    = edge_q;
    mode_d    = mode_q;
    ready_d   = ready_q;
    rx_dv_d   = 1'b0;
    sclk_d    = sclk_q;
    copi_d    = copi_q;
    cs_n_d    = cs_n_q;
    case (state_q)
      ST_IDLE: begin
        sclk_d = mode_q[MODE_CPOL];
        if (accept) begin
          // New CPOL lands together with CS falling, before any SCLK edge
          ready_d = 1'b0;
          cs_n_d  = 1'b0;
          mode_d  = i_mode;
          sclk_d  = i_mode[MODE_CPOL];
          edge_d  = '0;
          rx_sh_d = '0;
          if (!i_mode[MODE_CPHA]) begin
            copi_d  = head_bit(i_tx_data);
            tx_sh_d = advance(i_tx_data);
          end else begin
            copi_d  = 1'b0;
            tx_sh_d = i_tx_data;
          end
        end
      end
      ST_HOLD: begin
        if (tick) begin
          cs_n_d    = 1'b1;
          rx_dv_d   = 1'b1;
          rx_data_d = rx_sh_q;
          ready_d   = 1'b1;
          copi_d    = 1'b0;
        end
      end
      default: ;
    endcase
    if (edge_now) begin
      sclk_d = ~sclk_q;
      edge_d = edge_q + 1'b1;
      if (sample) begin
        rx_sh_d = MSB_FIRST ? {rx_sh_q[DATA_WIDTH-2:0], i_spi_cipo}
                            : {i_spi_cipo, rx_sh_q[DATA_WIDTH-1:1]};
      end else if (edge_q != LAST_EDGE) begin
        copi_d  = head_bit(tx_sh_q);
        tx_sh_d = advance(tx_sh_q);
      end
    end
  end

  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      tx_sh_q   <= '0;
      rx_sh_q   <= '0;
      rx_data_q <= '0;
      edge_q    <= '0;
      mode_q    <= 2'b00;
      ready_q   <= 1'b1;
      rx_dv_q   <= 1'b0;
      sclk_q    <= 1'b0;
      copi_q    <= 1'b0;
      cs_n_q    <= 1'b1;
    end else begin
      tx_sh_q   <= tx_sh_d;
      rx_sh_q   <= rx_sh_d;
      rx_data_q <= rx_data_d;
      edge_q    <= edge_d;
      mode_q    <= mode_d;
      ready_q   <= ready_d;
      rx_dv_q   <= rx_dv_d;
      sclk_q    <= sclk_d;
      copi_q    <= copi_d;
      cs_n_q    <= cs_n_d;
    end
  end

  assign o_tx_ready = ready_q;
  assign o_rx_dv    = rx_dv_q;
  assign o_rx_data  = rx_data_q;
  assign o_spi_clk  = sclk_q;
  assign o_spi_copi = copi_q;
  assign o_spi_cs_n = cs_n_q;

endmodule

// File: tb/tb_spi_controller_cfg.sv
// Directed bench: 8-bit MSB-first DIV=2 instance plus a 16-bit LSB-first DIV=1 instance.
module tb_spi_controller_cfg;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;

  logic [7:0]  tx_data8 = '0;
  logic        tx_dv8 = 1'b0;
  logic [1:0]  mode8 = 2'b00;
  logic        ready8, rx_dv8, sclk8, copi8, cs_n8, cipo8;
  logic [7:0]  rx_data8;
  logic        loop8 = 1'b0;
  logic        cipo_drv = 1'b0;
  assign cipo8 = loop8 ? copi8 : cipo_drv;

  logic [15:0] tx_data16 = '0;
  logic        tx_dv16 = 1'b0;
  logic [1:0]  mode16 = 2'b00;
  logic        ready16, rx_dv16, sclk16, copi16, cs_n16;
  logic [15:0] rx_data16;

  spi_controller_cfg dut8 (
    .i_clk(clk), .i_reset_n(rst_n), .i_tx_data(tx_data8), .i_tx_dv(tx_dv8), .i_mode(mode8),
    .o_tx_ready(ready8), .o_rx_dv(rx_dv8), .o_rx_data(rx_data8), .o_spi_clk(sclk8),
    .o_spi_copi(copi8), .i_spi_cipo(cipo8), .o_spi_cs_n(cs_n8)
  );

  spi_controller_cfg #(.DATA_WIDTH(16), .CLK_DIV(1), .MSB_FIRST(1'b0)) dut16 (
    .i_clk(clk), .i_reset_n(rst_n), .i_tx_data(tx_data16), .i_tx_dv(tx_dv16), .i_mode(mode16),
    .o_tx_ready(ready16), .o_rx_dv(rx_dv16), .o_rx_data(rx_data16), .o_spi_clk(sclk16),
    .o_spi_copi(copi16), .i_spi_cipo(copi16), .o_spi_cs_n(cs_n16)
  );

  // One transfer on dut8 with a peripheral model; optional stray request at edge inj_edge
  task automatic xfer8(input logic [7:0] data, input logic [1:0] mode, input logic loop,
                       input logic [7:0] pword, input int inj_edge,
                       output logic [7:0] copi_word, output logic [7:0] rx, output int latency,
                       output int n_edges, output int n_rise, output int n_rxdv,
                       output logic ready_bad, output logic sclk_bad);
    logic prev_cs, prev_sclk, done, inj_clear, leading;
    int   pidx;
    copi_word = '0; rx = '0; latency = -1; n_edges = 0; n_rise = 0; n_rxdv = 0;
    ready_bad = 1'b0; sclk_bad = 1'b0; done = 1'b0; inj_clear = 1'b0; pidx = 7;
    @(negedge clk);
    tx_data8 = data; mode8 = mode; loop8 = loop; tx_dv8 = 1'b1;
    if (mode[0]) cipo_drv = 1'b0;
    @(negedge clk);
    tx_dv8 = 1'b0;
    prev_cs = 1'b1; prev_sclk = sclk8;
    for (int c = 1; c <= 200 && !done; c++) begin
      if (inj_clear) begin tx_dv8 = 1'b0; inj_clear = 1'b0; end
      if (c == 1 && sclk8 !== mode[1]) sclk_bad = 1'b1;
      if (rx_dv8 === 1'b1) begin
        latency = c; n_rxdv++; rx = rx_data8; done = 1'b1;
      end else if (ready8 !== 1'b0) begin
        ready_bad = 1'b1;
      end
      if (!cs_n8 && !prev_cs && sclk8 !== prev_sclk) begin
        n_edges++;
        if (sclk8) n_rise++;
        leading = (sclk8 != mode[1]);
        if (leading ^ mode[0]) copi_word = {copi_word[6:0], copi8};
        else if (pidx >= 0) begin cipo_drv = pword[pidx]; pidx--; end
        if (n_edges == inj_edge) begin
          tx_dv8 = 1'b1; tx_data8 = ~data; mode8 = ~mode; inj_clear = 1'b1;
        end
      end
      if (!cs_n8 && prev_cs && !mode[0]) begin cipo_drv = pword[7]; pidx = 6; end
      prev_cs = cs_n8; prev_sclk = sclk8;
      if (!done) @(negedge clk);
    end
    tx_dv8 = 1'b0;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      if (rx_dv8 === 1'b1) n_rxdv++;
    end
    $display("xfer8 mode=%0d tx=%h copi=%h rx=%h latency=%0d edges=%0d", mode, data, copi_word, rx, latency, n_edges);
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    checks++; if (ready8 !== 1'b1) begin errors++; $display("FAIL reset_ready: got %b want 1", ready8); end
    checks++; if (rx_dv8 !== 1'b0) begin errors++; $display("FAIL reset_rx_dv: got %b want 0", rx_dv8); end
    checks++; if (rx_data8 !== 8'h00) begin errors++; $display("FAIL reset_rx_data: got %h want 00", rx_data8); end
    checks++; if (cs_n8 !== 1'b1) begin errors++; $display("FAIL reset_cs_n: got %b want 1", cs_n8); end
    checks++; if (copi8 !== 1'b0) begin errors++; $display("FAIL reset_copi: got %b want 0", copi8); end
    checks++; if (sclk8 !== 1'b0) begin errors++; $display("FAIL reset_sclk: got %b want 0", sclk8); end
    checks++; if (cs_n16 !== 1'b1) begin errors++; $display("FAIL reset_cs_n16: got %b want 1", cs_n16); end
    rst_n = 1'b1;
    repeat (2) @(negedge clk);
    checks++; if (ready8 !== 1'b1) begin errors++; $display("FAIL reset_release_ready: got %b want 1", ready8); end
    $display("reset done");
  endtask

  task automatic test_mode0_msb();
    logic [7:0] cw, rx; int lat, ne, nr, nx; logic rb, sb;
    xfer8(8'hA5, 2'b00, 1'b0, 8'h3C, 0, cw, rx, lat, ne, nr, nx, rb, sb);
    checks++; if (cw !== 8'hA5) begin errors++; $display("FAIL m0_copi_bits: got %h want a5", cw); end
    checks++; if (rx !== 8'h3C) begin errors++; $display("FAIL m0_rx: got %h want 3c", rx); end
    checks++; if (lat !== 35) begin errors++; $display("FAIL m0_latency: got %0d want 35", lat); end
    checks++; if (ne !== 16) begin errors++; $display("FAIL m0_edges: got %0d want 16", ne); end
    checks++; if (nr !== 8) begin errors++; $display("FAIL m0_rising: got %0d want 8", nr); end
    checks++; if (nx !== 1) begin errors++; $display("FAIL m0_rx_dv_count: got %0d want 1", nx); end
    checks++; if (rb !== 1'b0) begin errors++; $display("FAIL m0_ready_busy: got %b want 0", rb); end
    checks++; if (rx_data8 !== 8'h3C) begin errors++; $display("FAIL m0_rx_hold: got %h want 3c", rx_data8); end
    checks++; if (sclk8 !== 1'b0) begin errors++; $display("FAIL m0_sclk_idle: got %b want 0", sclk8); end
  endtask

  task automatic test_modes();
    logic [7:0] cw, rx, w; int lat, ne, nr, nx; logic rb, sb; logic [1:0] m;
    for (int mi = 0; mi < 4; mi++) begin
      for (int wi = 0; wi < 2; wi++) begin
        m = 2'(mi);
        w = (wi == 0) ? 8'h81 : 8'h7E;
        xfer8(w, m, 1'b1, 8'h00, 0, cw, rx, lat, ne, nr, nx, rb, sb);
        checks++; if (rx !== w) begin errors++; $display("FAIL modes_rx m=%0d: got %h want %h", m, rx, w); end
        checks++; if (cw !== w) begin errors++; $display("FAIL modes_copi m=%0d: got %h want %h", m, cw, w); end
        checks++; if (sclk8 !== m[1]) begin errors++; $display("FAIL modes_sclk_idle m=%0d: got %b want %b", m, sclk8, m[1]); end
        checks++; if (sb !== 1'b0) begin errors++; $display("FAIL modes_sclk_at_cs m=%0d: got %b want 0", m, sb); end
        checks++; if (ne !== 16 || nr !== 8) begin errors++; $display("FAIL modes_edges m=%0d: got %0d/%0d want 16/8", m, ne, nr); end
        checks++; if (lat !== 35) begin errors++; $display("FAIL modes_latency m=%0d: got %0d want 35", m, lat); end
      end
    end
  endtask

  task automatic test_lsb_w16();
    logic [15:0] cap; int lat; logic first_bit, prev_sclk, prev_cs, done;
    cap = '0; lat = -1; done = 1'b0;
    @(negedge clk);
    tx_data16 = 16'h1234; mode16 = 2'b00; tx_dv16 = 1'b1;
    @(negedge clk);
    tx_dv16 = 1'b0;
    first_bit = copi16;
    prev_sclk = sclk16; prev_cs = 1'b1;
    for (int c = 1; c <= 100 && !done; c++) begin
      if (rx_dv16 === 1'b1) begin lat = c; done = 1'b1; end
      if (!cs_n16 && !prev_cs && sclk16 && !prev_sclk) cap = {copi16, cap[15:1]};
      prev_sclk = sclk16; prev_cs = cs_n16;
      if (!done) @(negedge clk);
    end
    $display("xfer16 tx=1234 copi=%h rx=%h latency=%0d", cap, rx_data16, lat);
    checks++; if (first_bit !== 1'b0) begin errors++; $display("FAIL w16_first_bit: got %b want 0", first_bit); end
    checks++; if (cap !== 16'h1234) begin errors++; $display("FAIL w16_copi_order: got %h want 1234", cap); end
    checks++; if (rx_data16 !== 16'h1234) begin errors++; $display("FAIL w16_rx: got %h want 1234", rx_data16); end
    checks++; if (lat !== 34) begin errors++; $display("FAIL w16_latency: got %0d want 34", lat); end
  endtask

  task automatic test_back_to_back();
    logic [7:0] w [3];
    logic [7:0] rxw [$];
    int gaps [$];
    int acc, ncsfall, hi_run, g;
    logic pend, prev_cs;
    w[0] = 8'h11; w[1] = 8'hC4; w[2] = 8'h5E;
    acc = 0; ncsfall = 0; hi_run = 0; pend = 1'b0; prev_cs = 1'b1;
    loop8 = 1'b1;
    @(negedge clk);
    mode8 = 2'b00; tx_data8 = w[0]; tx_dv8 = 1'b1;
    for (int c = 0; c < 150; c++) begin
      if (pend) begin
        pend = 1'b0;
        if (acc < 3) tx_data8 = w[acc]; else tx_dv8 = 1'b0;
      end
      if (rx_dv8 === 1'b1) begin
        rxw.push_back(rx_data8);
        $display("b2b word rx=%h", rx_data8);
      end
      if (cs_n8) hi_run++;
      else if (prev_cs) begin
        ncsfall++;
        if (ncsfall > 1) gaps.push_back(hi_run);
        hi_run = 0;
      end
      if (ready8 && tx_dv8) begin acc++; pend = 1'b1; end
      prev_cs = cs_n8;
      @(negedge clk);
    end
    tx_dv8 = 1'b0;
    checks++; if (rxw.size() !== 3) begin errors++; $display("FAIL b2b_rx_count: got %0d want 3", rxw.size()); end
    checks++; if (ncsfall !== 3) begin errors++; $display("FAIL b2b_transfers: got %0d want 3", ncsfall); end
    for (int i = 0; i < 3; i++) begin
      checks++;
      if (i >= rxw.size() || rxw[i] !== w[i]) begin
        errors++; $display("FAIL b2b_rx_word%0d: got %h want %h", i, (i < rxw.size()) ? rxw[i] : 8'hxx, w[i]);
      end
    end
    for (int i = 0; i < 2; i++) begin
      g = (i < gaps.size()) ? gaps[i] : -1;
      checks++; if (g !== 1) begin errors++; $display("FAIL b2b_cs_gap%0d: got %0d want 1", i, g); end
    end
  endtask

  task automatic test_busy_ignore();
    logic [7:0] cw, rx; int lat, ne, nr, nx; logic rb, sb;
    xfer8(8'h5A, 2'b00, 1'b1, 8'h00, 5, cw, rx, lat, ne, nr, nx, rb, sb);
    checks++; if (rx !== 8'h5A) begin errors++; $display("FAIL busy_rx: got %h want 5a", rx); end
    checks++; if (rb !== 1'b0) begin errors++; $display("FAIL busy_ready: got %b want 0", rb); end
    checks++; if (nx !== 1) begin errors++; $display("FAIL busy_rx_dv_count: got %0d want 1", nx); end
    checks++; if (lat !== 35) begin errors++; $display("FAIL busy_latency: got %0d want 35", lat); end
    checks++; if (cs_n8 !== 1'b1) begin errors++; $display("FAIL busy_no_extra_cs: got %b want 1", cs_n8); end
  endtask

  task automatic test_reset_mid();
    logic [7:0] cw, rx; int lat, ne, nr, nx, n, c, spur; logic rb, sb, pc, ps;
    loop8 = 1'b1;
    @(negedge clk);
    tx_data8 = 8'hC3; mode8 = 2'b10; tx_dv8 = 1'b1;
    @(negedge clk);
    tx_dv8 = 1'b0;
    n = 0; c = 0; pc = cs_n8; ps = sclk8;
    while (n < 7 && c < 100) begin
      @(negedge clk);
      c++;
      if (!cs_n8 && !pc && sclk8 !== ps) n++;
      pc = cs_n8; ps = sclk8;
    end
    checks++; if (n !== 7) begin errors++; $display("FAIL rst_mid_reach_edge7: got %0d want 7", n); end
    rst_n = 1'b0;
    #1;
    checks++; if (cs_n8 !== 1'b1) begin errors++; $display("FAIL rst_mid_cs_n: got %b want 1", cs_n8); end
    checks++; if (sclk8 !== 1'b0) begin errors++; $display("FAIL rst_mid_sclk: got %b want 0", sclk8); end
    checks++; if (copi8 !== 1'b0) begin errors++; $display("FAIL rst_mid_copi: got %b want 0", copi8); end
    checks++; if (rx_data8 !== 8'h00) begin errors++; $display("FAIL rst_mid_rx_data: got %h want 00", rx_data8); end
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    spur = 0;
    for (int k = 0; k < 50; k++) begin
      @(negedge clk);
      if (rx_dv8 === 1'b1) spur++;
    end
    $display("reset mid-transfer at edge %0d, rx_dv pulses after=%0d", n, spur);
    checks++; if (ready8 !== 1'b1) begin errors++; $display("FAIL rst_mid_ready: got %b want 1", ready8); end
    checks++; if (spur !== 0) begin errors++; $display("FAIL rst_mid_rx_dv: got %0d want 0", spur); end
    xfer8(8'h96, 2'b00, 1'b1, 8'h00, 0, cw, rx, lat, ne, nr, nx, rb, sb);
    checks++; if (rx !== 8'h96) begin errors++; $display("FAIL rst_mid_next_rx: got %h want 96", rx); end
    checks++; if (lat !== 35) begin errors++; $display("FAIL rst_mid_next_latency: got %0d want 35", lat); end
  endtask

  initial begin
    test_reset();
    test_mode0_msb();
    test_modes();
    test_lsb_w16();
    test_back_to_back();
    test_busy_ignore();
    test_reset_mid();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
